// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the timekeeper/alarm setter/buttons and the alarm controller.
// The controller attaches as slave; whatever drives time, alarm and buttons is master.
interface alarm_ctrl_if;
   logic       tick;
   logic [3:0] t_h1, t_h0, t_m1, t_m0, t_s1, t_s0;
   logic [3:0] a_h1, a_h0, a_m1, a_m0;
   logic       alarm_en;
   logic       snooze_n;
   logic       stop_n;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_cnt;

   modport slave (
      input  tick, t_h1, t_h0, t_m1, t_m0, t_s1, t_s0,
      input  a_h1, a_h0, a_m1, a_m0, alarm_en, snooze_n, stop_n,
      output buzzer, ringing, snoozing, snooze_cnt
   );

   modport master (
      output tick, t_h1, t_h0, t_m1, t_m0, t_s1, t_s0,
      output a_h1, a_h0, a_m1, a_m0, alarm_en, snooze_n, stop_n,
      input  buzzer, ringing, snoozing, snooze_cnt
   );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: matches BCD hh:mm against the running clock, rings the
// buzzer with a 1 Hz pattern, and handles ring timeout, snooze and stop.
module alarm_ctrl #(
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3
) (
   input logic         clk,
   input logic         reset,
   alarm_ctrl_if.slave bus
);
   localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
   localparam logic [4:0] SNZ_MIN   = 5'(SNOOZE_MIN);
   localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNZ} state_t;

   state_t     r_state;
   logic [7:0] r_ring_cnt;
   logic [1:0] r_snooze_cnt;
   logic       r_buzzer, r_ringing, r_snoozing;
   logic [3:0] r_tg_h1, r_tg_h0, r_tg_m1, r_tg_m0;
   logic       r_snz_prev, r_stop_prev;

   logic       w_top, w_match_alarm, w_match_tgt;
   logic       w_snz_p, w_stop_p;
   logic [4:0] w_m0_sum, w_m0_sub;
   logic       w_m0_c, w_h_c;
   logic [3:0] w_m0_n, w_m1_n, w_h0_n, w_h1_n;

   // Only a tick landing on second 00 can match, so a match fires once per minute.
   assign w_top         = bus.tick && (bus.t_s1 == 4'd0) && (bus.t_s0 == 4'd0);
   assign w_match_alarm = w_top && ({bus.t_h1, bus.t_h0, bus.t_m1, bus.t_m0} ==
                                    {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0});
   assign w_match_tgt   = w_top && ({bus.t_h1, bus.t_h0, bus.t_m1, bus.t_m0} ==
                                    {r_tg_h1, r_tg_h0, r_tg_m1, r_tg_m0});
   assign w_snz_p       = r_snz_prev  & ~bus.snooze_n;
   assign w_stop_p      = r_stop_prev & ~bus.stop_n;

   // Snooze target = current hh:mm + SNOOZE_MIN, carried digit by digit in BCD.
   always_comb begin
      w_m0_sum = {1'b0, bus.t_m0} + SNZ_MIN;
      w_m0_sub = w_m0_sum - 5'd10;
      w_m0_c   = (w_m0_sum > 5'd9);
      w_m0_n   = w_m0_c ? w_m0_sub[3:0] : w_m0_sum[3:0];
      w_m1_n   = bus.t_m1;
      w_h_c    = 1'b0;
      w_h1_n   = bus.t_h1;
      w_h0_n   = bus.t_h0;
      if (w_m0_c) begin
         if (bus.t_m1 == 4'd5) begin
            w_m1_n = 4'd0;
            w_h_c  = 1'b1;
         end else begin
            w_m1_n = bus.t_m1 + 4'd1;
         end
      end
      if (w_h_c) begin
         if (bus.t_h1 == 4'd2 && bus.t_h0 == 4'd3) begin
            w_h1_n = 4'd0;
            w_h0_n = 4'd0;
         end else if (bus.t_h0 == 4'd9) begin
            w_h1_n = bus.t_h1 + 4'd1;
            w_h0_n = 4'd0;
         end else begin
            w_h0_n = bus.t_h0 + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ring_cnt   <= 8'd0;
         r_snooze_cnt <= 2'd0;
         r_buzzer     <= 1'b0;
         r_ringing    <= 1'b0;
         r_snoozing   <= 1'b0;
         r_tg_h1      <= 4'd0;
         r_tg_h0      <= 4'd0;
         r_tg_m1      <= 4'd0;
         r_tg_m0      <= 4'd0;
         r_snz_prev   <= 1'b1;
         r_stop_prev  <= 1'b1;
      end else begin
         r_snz_prev  <= bus.snooze_n;
         r_stop_prev <= bus.stop_n;
         case (r_state)
            S_IDLE: begin
               if (bus.alarm_en && w_match_alarm) begin
                  r_state      <= S_RING;
                  r_ring_cnt   <= 8'd0;
                  r_snooze_cnt <= 2'd0;
                  r_buzzer     <= 1'b1;
                  r_ringing    <= 1'b1;
               end
            end
            S_RING: begin
               if (!bus.alarm_en || w_stop_p) begin
                  r_state      <= S_IDLE;
                  r_snooze_cnt <= 2'd0;
                  r_buzzer     <= 1'b0;
                  r_ringing    <= 1'b0;
               end else if (w_snz_p && (r_snooze_cnt < SNZ_MAX)) begin
                  r_state      <= S_SNZ;
                  r_snooze_cnt <= r_snooze_cnt + 2'd1;
                  r_buzzer     <= 1'b0;
                  r_ringing    <= 1'b0;
                  r_snoozing   <= 1'b1;
                  r_tg_h1      <= w_h1_n;
                  r_tg_h0      <= w_h0_n;
                  r_tg_m1      <= w_m1_n;
                  r_tg_m0      <= w_m0_n;
               end else if (bus.tick) begin
                  // An exhausted snooze press is a no-op, so the tick still counts here.
                  if (r_ring_cnt == RING_LAST) begin
                     r_state   <= S_IDLE;
                     r_buzzer  <= 1'b0;
                     r_ringing <= 1'b0;
                  end else begin
                     r_ring_cnt <= r_ring_cnt + 8'd1;
                     r_buzzer   <= ~r_buzzer;
                  end
               end
            end
            S_SNZ: begin
               if (!bus.alarm_en || w_stop_p) begin
                  r_state      <= S_IDLE;
                  r_snooze_cnt <= 2'd0;
                  r_snoozing   <= 1'b0;
               end else if (w_match_tgt) begin
                  r_state    <= S_RING;
                  r_ring_cnt <= 8'd0;
                  r_buzzer   <= 1'b1;
                  r_ringing  <= 1'b1;
                  r_snoozing <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_buzzer   <= 1'b0;
               r_ringing  <= 1'b0;
               r_snoozing <= 1'b0;
            end
         endcase
      end
   end

   assign bus.buzzer     = r_buzzer;
   assign bus.ringing    = r_ringing;
   assign bus.snoozing   = r_snoozing;
   assign bus.snooze_cnt = r_snooze_cnt;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Random stimulus for alarm_ctrl against a minute-of-day reference model;
// time jumps steer the clock onto alarm and snooze-target minutes.
module tb_alarm_ctrl;
   localparam int RS = 10;
   localparam int SM = 5;
   localparam int MS = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alarm_ctrl_if bus();

   alarm_ctrl #(.RING_SECS(RS), .SNOOZE_MIN(SM), .MAX_SNOOZE(MS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference state: ringing/snoozing flags and counts in plain integers.
   bit m_ring, m_snz, m_buz, m_pst, m_psn;
   int m_cnt, m_rc, m_tgt;

   int alist [5] = '{450, 1438, 1439, 597, 1195};
   int alarm_min;
   int cur;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_time(input int s);
      int h, m, sec;
      h = s / 3600; m = (s / 60) % 60; sec = s % 60;
      bus.t_h1 = 4'(h / 10); bus.t_h0 = 4'(h % 10);
      bus.t_m1 = 4'(m / 10); bus.t_m0 = 4'(m % 10);
      bus.t_s1 = 4'(sec / 10); bus.t_s0 = 4'(sec % 10);
   endtask

   task automatic set_alarm(input int mn);
      alarm_min = mn;
      bus.a_h1 = 4'((mn / 60) / 10); bus.a_h0 = 4'((mn / 60) % 10);
      bus.a_m1 = 4'((mn % 60) / 10); bus.a_m0 = 4'((mn % 60) % 10);
   endtask

   function automatic bit at_minute(input bit tk, input int s, input int mn);
      return tk && (s % 60 == 0) && (s / 60 == mn);
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit tk, input bit sn, input bit st);
      bit stop_p, snz_p;
      if (rst) begin
         m_ring = 0; m_snz = 0; m_buz = 0; m_cnt = 0; m_rc = 0; m_tgt = 0;
         m_pst = 1; m_psn = 1;
         return;
      end
      stop_p = m_pst && !st;
      snz_p  = m_psn && !sn;
      m_pst = st; m_psn = sn;
      if (m_ring) begin
         if (!en || stop_p) begin
            m_ring = 0; m_buz = 0; m_cnt = 0;
         end else if (snz_p && m_cnt < MS) begin
            m_ring = 0; m_snz = 1; m_buz = 0; m_cnt++;
            m_tgt = (cur / 60 + SM) % 1440;
         end else if (tk) begin
            if (m_rc == RS - 1) begin
               m_ring = 0; m_buz = 0;
            end else begin
               m_rc++; m_buz = !m_buz;
            end
         end
      end else if (m_snz) begin
         if (!en || stop_p) begin
            m_snz = 0; m_cnt = 0;
         end else if (at_minute(tk, cur, m_tgt)) begin
            m_snz = 0; m_ring = 1; m_rc = 0; m_buz = 1;
         end
      end else if (en && at_minute(tk, cur, alarm_min)) begin
         m_ring = 1; m_rc = 0; m_cnt = 0; m_buz = 1;
      end
   endtask

   initial begin
      int r;
      bus.tick = 0; bus.alarm_en = 1; bus.snooze_n = 1; bus.stop_n = 1;
      set_alarm(450);
      cur = 450 * 60 - 3;
      set_time(cur);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         if (cyc > 0) begin
            chk("ringing",    {7'd0, bus.ringing},    {7'd0, m_ring});
            chk("snoozing",   {7'd0, bus.snoozing},   {7'd0, m_snz});
            chk("buzzer",     {7'd0, bus.buzzer},     {7'd0, m_buz});
            chk("snooze_cnt", {6'd0, bus.snooze_cnt}, 8'(m_cnt));
         end
         reset = (cyc < 2) || ($urandom_range(0, 399) == 0);
         if (bus.alarm_en) bus.alarm_en = ($urandom_range(0, 149) != 0);
         else              bus.alarm_en = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 11) == 0) bus.snooze_n = ~bus.snooze_n;
         if ($urandom_range(0, 29) == 0) bus.stop_n = ~bus.stop_n;
         if ($urandom_range(0, 299) == 0) set_alarm(alist[$urandom_range(0, 4)]);
         bus.tick = ($urandom_range(0, 1) == 1);
         if (bus.tick) begin
            r = $urandom_range(0, 99);
            if (m_snz && r < 15)                  cur = m_tgt * 60;
            else if (!m_ring && !m_snz && r < 8)  cur = alarm_min * 60;
            else if (r < 10)                      cur = $urandom_range(0, 86399);
            else                                  cur = (cur + 1) % 86400;
            set_time(cur);
         end
         model_step(reset, bus.alarm_en, bus.tick, bus.snooze_n, bus.stop_n);
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
